imm_gen_pipe: RTL and testbench

//  Pipelined RV32/RV64 immediate generator for the next-gen pipelined core.

---
 rtl/imm_gen_pipe.sv | 182 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Pipelined RV32/RV64 immediate generator. Sits between the IF/ID register
//   and the ID/EX register. It decodes instr[6:0] and produces the
//   sign-extended immediate for the I/S/B/U/J formats. An unsupported opcode
//   is flagged and counted.
//
//   The output register is backed by one skid entry, so an instruction that
//   is accepted while the output is stalled is kept until the output drains.
//   Order is preserved. in_ready is registered and is !skid_full.
//
// Parameters
//   XLEN   immediate width (32 or 64)
//   CNT_W  illegal-opcode counter width (saturating)
//
// Ports
//   clk, rst_n     clock, async active-low reset
//   in_valid       instr is valid
//   in_ready       block accepts instr this cycle (registered)
//   instr          raw 32-bit instruction word
//   out_valid      imm/fmt/illegal are valid
//   out_ready      downstream consumes the output this cycle
//   imm            sign-extended immediate
//   fmt            0=I 1=S 2=B 3=U 4=J 7=none
//   illegal        opcode is not in the decode table
//   illegal_cnt    saturating count of accepted illegal instrs
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_NONE = 3'd7;

    // One decoded result; the output register and the skid entry share it.
    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } res_t;

    localparam res_t RES_RST = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    // Raw immediate fields, held signed so a size cast to XLEN
    // sign-extends them.
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    logic [6:0]         opcode;
    res_t               dec;

    assign opcode = instr[6:0];
    assign imm_i  = instr[31:20];
    assign imm_s  = {instr[31:25], instr[11:7]};
    assign imm_b  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec = '{imm: '0, fmt: FMT_NONE, illegal: 1'b1};
        unique case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec = '{imm: XLEN'(imm_i), fmt: FMT_I, illegal: 1'b0};
            end
            // OP-IMM-32 exists only on RV64. On RV32 it stays illegal.
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec = '{imm: XLEN'(imm_i), fmt: FMT_I, illegal: 1'b0};
                end
            end
            7'b0100011: dec = '{imm: XLEN'(imm_s), fmt: FMT_S, illegal: 1'b0};
            7'b1100011: dec = '{imm: XLEN'(imm_b), fmt: FMT_B, illegal: 1'b0};
            7'b0110111, 7'b0010111: begin
                dec = '{imm: XLEN'(imm_u), fmt: FMT_U, illegal: 1'b0};
            end
            7'b1101111: dec = '{imm: XLEN'(imm_j), fmt: FMT_J, illegal: 1'b0};
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register + skid entry
    // ------------------------------------------------------------------
    res_t             out_q,      out_d;
    logic             out_vld_q,  out_vld_d;
    res_t             skid_q,     skid_d;
    logic             skid_vld_q, skid_vld_d;
    logic             rdy_q,      rdy_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic accept;
    logic out_free;

    assign accept   = in_valid & rdy_q;
    // The output register can take new data this edge: it is empty,
    // or its current contents are consumed at this edge.
    assign out_free = ~out_vld_q | out_ready;

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        cnt_d      = cnt_q;

        if (out_free) begin
            if (skid_vld_q) begin
                // rdy_q is low whenever the skid is full, so no new accept
                // can collide with this move.
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                out_d     = dec;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            // Output is stalled. Park the new result in the skid entry.
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end

        rdy_d = ~skid_vld_d;

        // Count on the input side only, so a stalled output does not
        // count more than once.
        if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // in_ready resets low and rises on the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= RES_RST;
            out_vld_q  <= 1'b0;
            skid_q     <= RES_RST;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = out_vld_q;
    assign imm         = out_q.imm;
    assign fmt         = out_q.fmt;
    assign illegal     = out_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Two instances receive the same inputs:
//     - dut32: XLEN=32, CNT_W=16
//     - dut64: XLEN=64, CNT_W=2
//   The reference model holds accepted instructions in a FIFO of up to two
//   entries. The head of the FIFO is the expected output. Each immediate is
//   rebuilt from the instruction bit fields with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [15:0] cnt32;

    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [1:0]  cnt64;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .fmt(fmt32), .illegal(illegal32), .illegal_cnt(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .fmt(fmt64), .illegal(illegal64), .illegal_cnt(cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    logic [31:0] q[$];
    bit          armed = 0;
    int          c32   = 0;
    int          c64   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sign-interpret an n-bit field.
    function automatic longint sx(input longint v, input int n);
        longint full = longint'(1) << n;
        return (v >= (full >> 1)) ? v - full : v;
    endfunction

    function automatic longint fld(input longint unsigned u, input int lo, input int n);
        return longint'((u >> lo) % (longint'(1) << n));
    endfunction

    task automatic ref_dec(input logic [31:0] ins, input bit x64,
                           output logic [63:0] imm_e, output logic [2:0] fmt_e,
                           output logic ill_e);
        longint unsigned u = longint'(ins);
        longint v = 0;
        int op = int'(ins % 128);
        fmt_e = 3'd7;
        ill_e = 1'b0;
        case (op)
            'h13, 'h03, 'h67: begin v = sx(fld(u, 20, 12), 12); fmt_e = 0; end
            'h1B: if (x64) begin v = sx(fld(u, 20, 12), 12); fmt_e = 0; end
                  else ill_e = 1'b1;
            'h23: begin v = sx(fld(u, 25, 7) * 32 + fld(u, 7, 5), 12); fmt_e = 1; end
            'h63: begin
                v = sx(fld(u, 31, 1) * 4096 + fld(u, 7, 1) * 2048 +
                       fld(u, 25, 6) * 32 + fld(u, 8, 4) * 2, 13);
                fmt_e = 2;
            end
            'h37, 'h17: begin v = sx(fld(u, 12, 20) * 4096, 32); fmt_e = 3; end
            'h6F: begin
                v = sx(fld(u, 31, 1) * (1 << 20) + fld(u, 12, 8) * 4096 +
                       fld(u, 20, 1) * 2048 + fld(u, 21, 10) * 2, 21);
                fmt_e = 4;
            end
            default: ill_e = 1'b1;
        endcase
        imm_e = x64 ? 64'(v) : (64'(v) & 64'hFFFF_FFFF);
    endtask

    function automatic bit exp_rdy();
        return armed && (q.size() < 2);
    endfunction

    task automatic check_all();
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        chk("in_ready32", 64'(in_ready32), 64'(exp_rdy()));
        chk("in_ready64", 64'(in_ready64), 64'(exp_rdy()));
        chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
        chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
        if (q.size() > 0) begin
            ref_dec(q[0], 1'b0, e_imm, e_fmt, e_ill);
            chk("imm32", 64'(imm32), e_imm);
            chk("fmt32", 64'(fmt32), 64'(e_fmt));
            chk("illegal32", 64'(illegal32), 64'(e_ill));
            ref_dec(q[0], 1'b1, e_imm, e_fmt, e_ill);
            chk("imm64", imm64, e_imm);
            chk("fmt64", 64'(fmt64), 64'(e_fmt));
            chk("illegal64", 64'(illegal64), 64'(e_ill));
        end
        chk("cnt32", 64'(cnt32), 64'(c32));
        chk("cnt64", 64'(cnt64), 64'(c64));
    endtask

    // One clock: update the model with the handshakes at the rising edge,
    // then check on the falling edge.
    task automatic cyc();
        bit          acc;
        bit          con;
        logic [31:0] ins;
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        acc = in_valid && exp_rdy();
        con = (q.size() > 0) && out_ready;
        ins = instr;
        @(posedge clk);
        if (rst_n) begin
            if (con) void'(q.pop_front());
            if (acc) begin
                q.push_back(ins);
                ref_dec(ins, 1'b0, e_imm, e_fmt, e_ill);
                if (e_ill && c32 < 65535) c32++;
                ref_dec(ins, 1'b1, e_imm, e_fmt, e_ill);
                if (e_ill && c64 < 3) c64++;
            end
            armed = 1;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic ordy);
        in_valid  = iv;
        instr     = ins;
        out_ready = ordy;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ov32"}, 64'(out_valid32), 64'd0);
        chk({tag, "_ov64"}, 64'(out_valid64), 64'd0);
        chk({tag, "_imm32"}, 64'(imm32), 64'd0);
        chk({tag, "_imm64"}, imm64, 64'd0);
        chk({tag, "_fmt32"}, 64'(fmt32), 64'd7);
        chk({tag, "_fmt64"}, 64'(fmt64), 64'd7);
        chk({tag, "_ill32"}, 64'(illegal32), 64'd0);
        chk({tag, "_cnt32"}, 64'(cnt32), 64'd0);
        chk({tag, "_cnt64"}, 64'(cnt64), 64'd0);
    endtask

    logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h00};

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        chk("reset_rdy32", 64'(in_ready32), 64'd0);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        cyc();
        chk("rdy_after_reset", 64'(in_ready32), 64'd1);

        // addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 1'b1); cyc();
        chk("t1_imm", 64'(imm32), 64'hFFFF_FFFF);
        chk("t1_fmt", 64'(fmt32), 64'd0);

        // Back-to-back, one result per cycle
        drive(1'b1, 32'hFE112E23, 1'b1); cyc();
        chk("t2_sw", 64'(imm32), 64'hFFFF_FFFC);
        drive(1'b1, 32'hFE000CE3, 1'b1); cyc();
        chk("t2_beq", 64'(imm32), 64'hFFFF_FFF8);
        drive(1'b1, 32'h123450B7, 1'b1); cyc();
        chk("t2_lui", 64'(imm32), 64'h1234_5000);
        drive(1'b1, 32'h0010006F, 1'b1); cyc();
        chk("t2_jal", 64'(imm32), 64'h0000_0800);
        chk("t2_jal_fmt", 64'(fmt32), 64'd4);
        drive(1'b0, 32'h0, 1'b1); cyc();

        // Backpressure: 3 offered, 2 held, 3rd waits
        drive(1'b1, 32'h00100093, 1'b0); cyc();
        drive(1'b1, 32'h00200093, 1'b0); cyc();
        drive(1'b1, 32'h00300093, 1'b0); cyc();
        chk("t3_full_rdy", 64'(in_ready32), 64'd0);
        chk("t3_hold", 64'(imm32), 64'd1);
        out_ready = 1'b1; cyc();
        chk("t3_second", 64'(imm32), 64'd2);
        cyc();
        chk("t3_third", 64'(imm32), 64'd3);
        drive(1'b0, 32'h0, 1'b1); cyc();

        // Illegal opcode held stalled
        drive(1'b1, 32'h00000000, 1'b0); cyc();
        chk("t4_ill", 64'(illegal32), 64'd1);
        chk("t4_fmt", 64'(fmt32), 64'd7);
        chk("t4_imm", 64'(imm32), 64'd0);
        in_valid = 1'b0;
        repeat (5) cyc();
        chk("t4_cnt", 64'(cnt32), 64'd1);
        out_ready = 1'b1; cyc();

        // Saturation on the CNT_W=2 instance
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ($urandom() & 32'hFFFF_FF80) | 32'h7F, 1'b1); cyc();
        end
        drive(1'b0, 32'h0, 1'b1); cyc();
        chk("t5_sat64", 64'(cnt64), 64'd3);
        chk("t5_cnt32", 64'(cnt32), 64'd6);

        // RV64 forms
        drive(1'b1, 32'h8000001B, 1'b1); cyc();
        chk("t7_addiw", imm64, 64'hFFFF_FFFF_FFFF_F800);
        chk("t7_addiw_fmt", 64'(fmt64), 64'd0);
        chk("t7_addiw_rv32ill", 64'(illegal32), 64'd1);
        drive(1'b1, 32'h800000B7, 1'b1); cyc();
        chk("t7_lui", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("t7_lui_fmt", 64'(fmt64), 64'd3);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = $urandom();
            drive($urandom_range(0, 3) != 0,
                  (r & 32'hFFFF_FF80) | 32'(ops[$urandom_range(0, 11)]),
                  $urandom_range(0, 9) < 7);
            cyc();
        end

        // Reset mid-stall with the skid full
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00000013 | ($urandom() & 32'hFFF0_0000), 1'b0); cyc();
        end
        chk("t6_full", 64'(in_ready32), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        q.delete(); armed = 0; c32 = 0; c64 = 0;
        chk_reset_vals("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        cyc();
        chk("t6_rdy", 64'(in_ready32), 64'd1);
        chk("t6_rdy64", 64'(in_ready64), 64'd1);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] r;
            r = $urandom();
            drive($urandom_range(0, 1) != 0,
                  (r & 32'hFFFF_FF80) | 32'(ops[$urandom_range(0, 11)]),
                  $urandom_range(0, 1) != 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
